i2c_slave_regs: RTL and testbench
=================================

# i2c_slave_regs

I2C target (slave) that answers a fixed 7-bit address and exposes an 8-bit register-pointer interface to local logic. It is the responder end of the I2C link driven by the team's Wishbone I2C master: it decodes START/STOP, address, register pointer and data bytes, and returns read data. It sits between the board I2C pins and a local register bank, typically on a peripheral board or in a loopback test harness.

## Interface
- SLAVE_ADDR, 7'h42, 7-bit address the block answers to.
- clk  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high.
- i2c_scl  in  1  bus clock, input only; the block never stretches SCL.
- i2c_sda  inout  1  open-drain: driven 1'b0 or 1'bz, never 1'b1.
- reg_addr  out  8  register pointer for the current access.
- reg_wdata  out  8  write data, valid while reg_we=1.
- reg_we  out  1  one-clk write strobe.
- reg_rd  out  1  one-clk read request for reg_addr.
- reg_rdata  in  8  read data; must be valid on the clk after reg_rd.
- busy  out  1  high from address match until STOP, NACK-end or mismatch.

## Operation
- SCL and SDA pass through 2-flop synchronizers plus one history flop; edges are detected on synchronized values.
- START/repeated START: SDA falls while SCL high. STOP: SDA rises while SCL high. Either one, from any state, aborts the current byte.
- Bits are sampled on SCL rising edges, MSB first. The block changes SDA only on SCL falling edges.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, WAIT_STOP.
- START moves to ADDR with bit count 0. STOP moves to IDLE and releases SDA.
- ADDR: after the 8th rising edge:
  - If byte[7:1] != SLAVE_ADDR, go to IDLE and never drive SDA.
  - On a match, drive ACK low from the next SCL fall to the following SCL fall. Then go to PTR if R/W=0, or RDATA if R/W=1.
- PTR: 8 bits load the pointer, then ACK, then WDATA.
- WDATA: after the 8th rising edge:
  - Pulse reg_we for one clk with reg_addr=pointer and reg_wdata=byte.
  - ACK, then increment the pointer mod 256 (0xFF wraps to 0x00).
- Read data prefetch: reg_rd pulses on the rising edge of the ACK bit that precedes the read byte, i.e. the 9th clock of the ADDR byte or the master ACK. reg_rdata is captured into the shift register one clk later.
- RDATA: the block drives each bit on SCL falls; a 1 bit means SDA is released. After the 8th bit, SDA is released and the block moves to RDATA_MACK.
- RDATA_MACK: the master's ACK/NACK is sampled on the 9th rising edge.
  - ACK(0): increment the pointer, pulse reg_rd, return to RDATA.
  - NACK(1): go to WAIT_STOP with SDA released.
- A read with no preceding pointer write uses the retained pointer.
- Reset values: i2c_sda=z, reg_we=0, reg_rd=0, reg_addr=0, reg_wdata=0, busy=0, pointer=0, state=IDLE.

## Timing
- Requirement on the bus: SCL high and low phases ≥ 4 clk each, so clk ≥ 8× SCL.
- Edge/START/STOP detection latency: 3 clk after the pin changes.
- SDA update: 1 clk after a detected SCL fall. This stays within the I2C hold window at ≥ 8× oversampling.
- reg_we occurs 1 clk after the detected 8th rising edge of the data byte.
- reg_rd is issued ≥ 3 clk before the SCL fall that drives the first bit of the read byte.
- Simultaneous START detect and SCL edge: START wins.
- Reset mid-transfer: SDA is released on the clk after reset is sampled, and no strobe is emitted.
- STOP mid-byte: no reg_we is issued for the partial byte, and the pointer is unchanged unless PTR had completed.

## Structure
- Package i2c_pkg holds:
  - the state enum;
  - constants I2C_ACK=1'b0 and I2C_NACK=1'b1;
  - the default SLAVE_ADDR.
- Sub-module i2c_line_sync contains the synchronizers, scl_rise/scl_fall detection and start_det/stop_det. The FSM, shift register, bit counter and pointer stay in i2c_slave_regs.

## Test plan
- Single write: START, 0x84, 0x10, 0xA5, STOP -> three ACKs; exactly one reg_we with reg_addr=0x10, reg_wdata=0xA5; busy falls after STOP.
- Burst wrap: START, 0x84, 0xFE, 0x11, 0x22, 0x33, STOP -> reg_we at addresses 0xFE, 0xFF, 0x00 with data 0x11, 0x22, 0x33.
- Random read: START, 0x84, 0x20, Sr, 0x85, read two bytes (master ACK then NACK), STOP, with model reg_rdata=addr+0x20 -> bus bytes 0x40, 0x41; exactly two reg_rd pulses (0x20, 0x21); SDA released after the NACK.
- Address mismatch: START, 0x90, 0x10, STOP -> SDA never driven low by the block; no reg_we/reg_rd; busy stays 0.
- Abort: START, 0x84, 4 bits of the pointer, STOP, then a read at 0x85 -> no reg_we; the read uses pointer 0x00.
- Reset mid-read: assert reset for 1 clk while the block drives a 0 data bit -> SDA is z the next clk and state is IDLE; a following single write succeeds.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bus constants for the I2C register target
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_MACK,
        ST_WAIT_STOP
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [6:0] I2C_SLAVE_ADDR_DEFAULT = 7'h42;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizers with edge, START and STOP detection
// Ports: clk, reset (sync, active-high); scl_in/sda_in raw pins;
// scl_rise/scl_fall/start_det/stop_det one-clk pulses; sda_smp is SDA aligned with the pulses.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_smp,
    output logic start_det,
    output logic stop_det
);

    // [0] first sync stage, [1] second sync stage, [2] history
    logic [2:0] scl_sync_q, scl_sync_d;
    logic [2:0] sda_sync_q, sda_sync_d;
    logic       scl_rise_q, scl_rise_d;
    logic       scl_fall_q, scl_fall_d;
    logic       sda_smp_q,  sda_smp_d;
    logic       start_q,    start_d;
    logic       stop_q,     stop_d;

    always_comb begin
        scl_sync_d = {scl_sync_q[1:0], scl_in};
        sda_sync_d = {sda_sync_q[1:0], sda_in};
        scl_rise_d = scl_sync_q[1] & ~scl_sync_q[2];
        scl_fall_d = ~scl_sync_q[1] & scl_sync_q[2];
        // SDA transitions only count as START/STOP while SCL is stably high
        start_d    = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[1] & sda_sync_q[2];
        stop_d     = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[1] & ~sda_sync_q[2];
        // registered alongside the pulses so the FSM sees the SDA level of that edge
        sda_smp_d  = sda_sync_q[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            sda_smp_q  <= 1'b1;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            sda_smp_q  <= sda_smp_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign sda_smp   = sda_smp_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target with 8-bit register pointer and local register strobes
// Ports: clk, reset (sync, active-high); i2c_scl input, i2c_sda open-drain;
// reg_addr/reg_wdata/reg_we write side, reg_rd/reg_rdata read side (data valid clk after reg_rd);
// busy high from address match until STOP, NACK or mismatch.
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = I2C_SLAVE_ADDR_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic scl_rise, scl_fall, sda_smp, start_det, stop_det;

    i2c_line_sync u_line_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (i2c_scl),
        .sda_in    (i2c_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_smp   (sda_smp),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       reg_we_q, reg_we_d;
    logic       reg_rd_q, reg_rd_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       rd_pend_q, rd_pend_d;
    logic [7:0] rx_byte;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        reg_we_d    = 1'b0;
        reg_rd_d    = 1'b0;
        reg_wdata_d = reg_wdata_q;
        rd_pend_d   = reg_rd_q;
        rx_byte     = {shift_q[6:0], sda_smp};

        // read data arrives the clk after reg_rd; SCL cannot fall again that soon
        if (rd_pend_q) begin
            shift_d = reg_rdata;
        end

        case (state_q)
            ST_ADDR, ST_PTR, ST_WDATA: begin
                if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        if (state_q == ST_ADDR) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = rx_byte[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                            end
                        end else if (state_q == ST_PTR) begin
                            ptr_d   = rx_byte;
                            state_d = ST_PTR_ACK;
                        end else begin
                            reg_we_d    = 1'b1;
                            reg_wdata_d = rx_byte;
                            state_d     = ST_WDATA_ACK;
                        end
                    end
                end
            end

            // bit_cnt 8: waiting for the fall that starts the ACK; 0: ACK driven; 1: 9th rise seen
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                if (scl_fall && bit_cnt_q == 4'd8) begin
                    sda_oe_d  = 1'b1;
                    bit_cnt_d = 4'd0;
                end else if (scl_rise) begin
                    bit_cnt_d = 4'd1;
                    if (state_q == ST_ADDR_ACK && rw_q) begin
                        reg_rd_d = 1'b1;
                    end
                end else if (scl_fall && bit_cnt_q == 4'd1) begin
                    bit_cnt_d = 4'd0;
                    sda_oe_d  = 1'b0;
                    if (state_q == ST_ADDR_ACK) begin
                        if (rw_q) begin
                            state_d  = ST_RDATA;
                            sda_oe_d = ~shift_q[7];
                        end else begin
                            state_d = ST_PTR;
                        end
                    end else begin
                        if (state_q == ST_WDATA_ACK) begin
                            ptr_d = ptr_q + 8'd1;
                        end
                        state_d = ST_WDATA;
                    end
                end
            end

            // MSB is already on the line when entering; each fall presents the next bit
            ST_RDATA: begin
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (scl_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RDATA_MACK;
                    end else begin
                        sda_oe_d = ~shift_q[6];
                        shift_d  = {shift_q[6:0], 1'b0};
                    end
                end
            end

            ST_RDATA_MACK: begin
                if (scl_rise) begin
                    if (sda_smp == I2C_ACK) begin
                        ptr_d     = ptr_q + 8'd1;
                        reg_rd_d  = 1'b1;
                        bit_cnt_d = 4'd1;
                    end else begin
                        state_d = ST_WAIT_STOP;
                        busy_d  = 1'b0;
                    end
                end else if (scl_fall && bit_cnt_q == 4'd1) begin
                    bit_cnt_d = 4'd0;
                    state_d   = ST_RDATA;
                    sda_oe_d  = ~shift_q[7];
                end
            end

            default: begin
            end
        endcase

        // bus conditions override any edge handling in the same clk
        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            ptr_d     = ptr_q;
            reg_we_d  = 1'b0;
            reg_rd_d  = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            ptr_d     = ptr_q;
            reg_we_d  = 1'b0;
            reg_rd_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            ptr_q       <= 8'h00;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            reg_wdata_q <= 8'h00;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            reg_we_q    <= reg_we_d;
            reg_rd_q    <= reg_rd_d;
            reg_wdata_q <= reg_wdata_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    assign i2c_sda   = sda_oe_q ? 1'b0 : 1'bz;
    assign reg_addr  = ptr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_rd    = reg_rd_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb/tb_i2c_slave_regs.sv - directed bus-level bench for i2c_slave_regs
module tb_i2c_slave_regs;

    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       m_scl;
    logic       m_sda_oe;
    logic       i2c_scl;
    wire        i2c_sda;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    int         we_cnt = 0;
    int         rd_cnt = 0;
    int         slave_low_cnt = 0;
    logic       busy_seen = 1'b0;
    logic [7:0] we_addr_q [$];
    logic [7:0] we_data_q [$];
    logic [7:0] rd_addr_q [$];

    logic [7:0] burst_bytes [5] = '{8'h84, 8'hFE, 8'h11, 8'h22, 8'h33};
    logic [7:0] burst_addr  [3] = '{8'hFE, 8'hFF, 8'h00};

    always #5 clk = ~clk;

    assign i2c_scl = m_scl;
    assign i2c_sda = m_sda_oe ? 1'b0 : 1'bz;
    pullup (i2c_sda);

    i2c_slave_regs dut (
        .clk       (clk),
        .reset     (reset),
        .i2c_scl   (i2c_scl),
        .i2c_sda   (i2c_sda),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // local register bank: one-clk read latency, content = address + 0x20
    always @(posedge clk) begin
        if (reg_rd) reg_rdata <= reg_addr + 8'h20;
    end

    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt++;
            we_addr_q.push_back(reg_addr);
            we_data_q.push_back(reg_wdata);
        end
        if (reg_rd) begin
            rd_cnt++;
            rd_addr_q.push_back(reg_addr);
        end
        if (!m_sda_oe && i2c_sda === 1'b0) slave_low_cnt++;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        we_cnt = 0;
        rd_cnt = 0;
        slave_low_cnt = 0;
        busy_seen = 1'b0;
        we_addr_q.delete();
        we_data_q.delete();
        rd_addr_q.delete();
    endtask

    task automatic bus_start();
        m_sda_oe = 1'b0; tick(Q);
        m_scl = 1'b1;    tick(Q);
        m_sda_oe = 1'b1; tick(Q);
        m_scl = 1'b0;    tick(Q);
    endtask

    task automatic bus_stop();
        m_sda_oe = 1'b1; tick(Q);
        m_scl = 1'b1;    tick(Q);
        m_sda_oe = 1'b0; tick(2 * Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda_oe = ~b; tick(Q);
        m_scl = 1'b1;  tick(2 * Q);
        m_scl = 1'b0;  tick(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda_oe = 1'b0; tick(Q);
        m_scl = 1'b1;    tick(Q);
        b = i2c_sda;     tick(Q);
        m_scl = 1'b0;    tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(mack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;

        reset = 1'b1;
        m_scl = 1'b1;
        m_sda_oe = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);

        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_we", reg_we, 1'b0);
        check_eq("rst_rd", reg_rd, 1'b0);
        check_eq("rst_addr", reg_addr, 8'h00);
        check_eq("rst_wdata", reg_wdata, 8'h00);
        check_eq("rst_sda", i2c_sda, 1'b1);

        // aborted pointer write, then read from the untouched pointer
        clear_log();
        bus_start();
        write_byte(8'h84, ack); check_eq("abort_addr_ack", ack, 1'b0);
        write_bit(1'b0); write_bit(1'b0); write_bit(1'b0); write_bit(1'b1);
        bus_stop();
        check_eq("abort_we_cnt", we_cnt, 0);
        check_eq("abort_busy", busy, 1'b0);
        bus_start();
        write_byte(8'h85, ack); check_eq("abort_rd_ack", ack, 1'b0);
        read_byte(d, 1'b1);
        check_eq("abort_rd_data", d, 8'h20);
        bus_stop();
        check_eq("abort_rd_cnt", rd_cnt, 1);
        check_eq("abort_rd_addr", rd_addr_q[0], 8'h00);

        // single write
        clear_log();
        bus_start();
        write_byte(8'h84, ack); check_eq("sw_ack0", ack, 1'b0);
        check_eq("sw_busy_mid", busy, 1'b1);
        write_byte(8'h10, ack); check_eq("sw_ack1", ack, 1'b0);
        write_byte(8'hA5, ack); check_eq("sw_ack2", ack, 1'b0);
        bus_stop();
        check_eq("sw_we_cnt", we_cnt, 1);
        check_eq("sw_we_addr", we_addr_q[0], 8'h10);
        check_eq("sw_we_data", we_data_q[0], 8'hA5);
        check_eq("sw_busy_end", busy, 1'b0);

        // burst write wrapping the pointer
        clear_log();
        bus_start();
        for (int i = 0; i < 5; i++) begin
            write_byte(burst_bytes[i], ack);
            check_eq($sformatf("bw_ack%0d", i), ack, 1'b0);
        end
        bus_stop();
        check_eq("bw_we_cnt", we_cnt, 3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("bw_addr%0d", i), we_addr_q[i], burst_addr[i]);
            check_eq($sformatf("bw_data%0d", i), we_data_q[i], burst_bytes[i + 2]);
        end

        // random read: pointer write, repeated START, two bytes
        clear_log();
        bus_start();
        write_byte(8'h84, ack); check_eq("rr_ack0", ack, 1'b0);
        write_byte(8'h20, ack); check_eq("rr_ack1", ack, 1'b0);
        bus_start();
        write_byte(8'h85, ack); check_eq("rr_ack2", ack, 1'b0);
        read_byte(d, 1'b0); check_eq("rr_byte0", d, 8'h40);
        read_byte(d, 1'b1); check_eq("rr_byte1", d, 8'h41);
        check_eq("rr_sda_rel", i2c_sda, 1'b1);
        bus_stop();
        check_eq("rr_rd_cnt", rd_cnt, 2);
        check_eq("rr_rd_addr0", rd_addr_q[0], 8'h20);
        check_eq("rr_rd_addr1", rd_addr_q[1], 8'h21);
        check_eq("rr_we_cnt", we_cnt, 0);

        // foreign address is ignored entirely
        clear_log();
        bus_start();
        write_byte(8'h90, ack); check_eq("mm_ack0", ack, 1'b1);
        write_byte(8'h10, ack); check_eq("mm_ack1", ack, 1'b1);
        bus_stop();
        check_eq("mm_sda_low", slave_low_cnt, 0);
        check_eq("mm_we_cnt", we_cnt, 0);
        check_eq("mm_rd_cnt", rd_cnt, 0);
        check_eq("mm_busy", busy_seen, 1'b0);

        // reset while the target drives a 0 data bit (pointer 0x21 -> data 0x41, MSB 0)
        clear_log();
        bus_start();
        write_byte(8'h85, ack); check_eq("rst_mid_ack", ack, 1'b0);
        tick(2);
        check_eq("rst_mid_drive", i2c_sda, 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("rst_mid_sda", i2c_sda, 1'b1);
        check_eq("rst_mid_busy", busy, 1'b0);
        tick(Q);
        bus_stop();
        clear_log();
        bus_start();
        write_byte(8'h84, ack); check_eq("post_ack0", ack, 1'b0);
        write_byte(8'h30, ack); check_eq("post_ack1", ack, 1'b0);
        write_byte(8'h5A, ack); check_eq("post_ack2", ack, 1'b0);
        bus_stop();
        check_eq("post_we_cnt", we_cnt, 1);
        check_eq("post_we_addr", we_addr_q[0], 8'h30);
        check_eq("post_we_data", we_data_q[0], 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
